// File: rtl/cond_seg_combiner.sv
// Conditional segment combiner: evaluates a masked compare once per transaction, then streams
// either the if-branch or else-branch segments one channel per beat with valid/ready handshake.
module cond_seg_combiner #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          input_bit,
    input  logic [WIDTH-1:0]          cond_mask,
    input  logic [WIDTH-1:0]          cond_value,
    input  logic [1:0]                mode,
    input  logic [CHANNELS*WIDTH-1:0] array_ref_wire,
    input  logic [CHANNELS*WIDTH-1:0] array_ref_m_wire,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          segment_combine,
    output logic [CW-1:0]             out_chan,
    output logic                      out_last,
    output logic [CNT_W-1:0]          if_count
);

    typedef enum logic [1:0] {StIdle, StEval, StStream} state_e;

    localparam logic [CW-1:0]    LastChan = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]    ChanOne  = CW'(1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e                    state_q, state_d;
    logic [CW-1:0]             chan_q, chan_d;
    logic                      sel_if_q, sel_if_d;
    logic [WIDTH-1:0]          bit_q, bit_d;
    logic [WIDTH-1:0]          mask_q, mask_d;
    logic [WIDTH-1:0]          value_q, value_d;
    logic [1:0]                mode_q, mode_d;
    logic [CHANNELS*WIDTH-1:0] if_arr_q, if_arr_d;
    logic [CHANNELS*WIDTH-1:0] else_arr_q, else_arr_d;
    logic                      out_valid_q, out_valid_d;
    logic [WIDTH-1:0]          seg_q, seg_d;
    logic                      out_last_q, out_last_d;
    logic                      in_ready_q, in_ready_d;
    logic [CNT_W-1:0]          if_count_q, if_count_d;
    logic                      match;

    function automatic logic [WIDTH-1:0] pick_seg(input logic [CHANNELS*WIDTH-1:0] arr,
                                                  input logic [CW-1:0] idx);
        pick_seg = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == CW'(k)) pick_seg = arr[k*WIDTH +: WIDTH];
        end
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid && in_ready_q) state_d = StEval;
            StEval:   state_d = StStream;
            StStream: if (out_ready && out_last_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign match = ((bit_q & mask_q) == (value_q & mask_q));

    // Output and datapath next-values; every port is driven from one of these registers.
    always_comb begin
        bit_d       = bit_q;
        mask_d      = mask_q;
        value_d     = value_q;
        mode_d      = mode_q;
        if_arr_d    = if_arr_q;
        else_arr_d  = else_arr_q;
        sel_if_d    = sel_if_q;
        chan_d      = chan_q;
        out_valid_d = out_valid_q;
        seg_d       = seg_q;
        out_last_d  = out_last_q;
        if_count_d  = if_count_q;
        in_ready_d  = (state_d == StIdle);
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    bit_d      = input_bit;
                    mask_d     = cond_mask;
                    value_d    = cond_value;
                    mode_d     = mode;
                    if_arr_d   = array_ref_wire;
                    else_arr_d = array_ref_m_wire;
                end
            end
            StEval: begin
                unique case (mode_q)
                    2'b00:   sel_if_d = match;
                    2'b01:   sel_if_d = 1'b1;
                    2'b10:   sel_if_d = 1'b0;
                    default: sel_if_d = !match;
                endcase
                chan_d      = '0;
                out_valid_d = 1'b1;
                seg_d       = sel_if_d ? pick_seg(if_arr_q, '0) : pick_seg(else_arr_q, '0);
                out_last_d  = (LastChan == '0);
                if (sel_if_d && (if_count_q != CntMax)) if_count_d = if_count_q + CntOne;
            end
            StStream: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        chan_d      = '0;
                        out_valid_d = 1'b0;
                        seg_d       = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        chan_d     = chan_q + ChanOne;
                        seg_d      = sel_if_q ? pick_seg(if_arr_q, chan_d)
                                              : pick_seg(else_arr_q, chan_d);
                        out_last_d = (chan_d == LastChan);
                    end
                end
            end
            default: begin
                chan_d      = '0;
                out_valid_d = 1'b0;
                seg_d       = '0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            mode_q      <= '0;
            if_arr_q    <= '0;
            else_arr_q  <= '0;
            sel_if_q    <= 1'b0;
            chan_q      <= '0;
            out_valid_q <= 1'b0;
            seg_q       <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            if_count_q  <= '0;
        end else begin
            bit_q       <= bit_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            mode_q      <= mode_d;
            if_arr_q    <= if_arr_d;
            else_arr_q  <= else_arr_d;
            sel_if_q    <= sel_if_d;
            chan_q      <= chan_d;
            out_valid_q <= out_valid_d;
            seg_q       <= seg_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            if_count_q  <= if_count_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign segment_combine = seg_q;
    assign out_chan        = chan_q;
    assign out_last        = out_last_q;
    assign if_count        = if_count_q;

endmodule

// File: tb/tb_cond_seg_combiner.sv
// Directed bench: default build plus a CNT_W=2 build and a CHANNELS=1 build sharing stimulus.
module tb_cond_seg_combiner;

    localparam logic [127:0] IfSegs   = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] ElseSegs = {4{32'd9}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, out_ready;
    logic [31:0]  input_bit, cond_mask, cond_value;
    logic [1:0]   mode;
    logic [127:0] arr_if, arr_else;

    logic        m_in_ready, m_valid, m_last;
    logic [31:0] m_seg;
    logic [1:0]  m_chan;
    logic [15:0] m_cnt;

    logic        s_in_ready, s_valid, s_last;
    logic [31:0] s_seg;
    logic [1:0]  s_chan;
    logic [1:0]  s_cnt;

    logic        o_in_ready, o_valid, o_last;
    logic [31:0] o_seg;
    logic [0:0]  o_chan;
    logic [15:0] o_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    cond_seg_combiner #(.WIDTH(32), .CHANNELS(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .input_bit(input_bit), .cond_mask(cond_mask), .cond_value(cond_value), .mode(mode),
        .array_ref_wire(arr_if), .array_ref_m_wire(arr_else), .out_valid(m_valid),
        .out_ready(out_ready), .segment_combine(m_seg), .out_chan(m_chan), .out_last(m_last),
        .if_count(m_cnt)
    );

    cond_seg_combiner #(.WIDTH(32), .CHANNELS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .input_bit(input_bit), .cond_mask(cond_mask), .cond_value(cond_value), .mode(mode),
        .array_ref_wire(arr_if), .array_ref_m_wire(arr_else), .out_valid(s_valid),
        .out_ready(out_ready), .segment_combine(s_seg), .out_chan(s_chan), .out_last(s_last),
        .if_count(s_cnt)
    );

    cond_seg_combiner #(.WIDTH(32), .CHANNELS(1), .CNT_W(16)) dut_one (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_in_ready),
        .input_bit(input_bit), .cond_mask(cond_mask), .cond_value(cond_value), .mode(mode),
        .array_ref_wire(arr_if[31:0]), .array_ref_m_wire(arr_else[31:0]), .out_valid(o_valid),
        .out_ready(out_ready), .segment_combine(o_seg), .out_chan(o_chan), .out_last(o_last),
        .if_count(o_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one transaction for a single cycle, then scrambles the operands; returns in EVAL.
    task automatic start_txn(input logic [1:0] m, input logic [31:0] ib, input logic [31:0] mk,
                             input logic [31:0] cv);
        mode = m; input_bit = ib; cond_mask = mk; cond_value = cv; in_valid = 1'b1;
        step();
        in_valid = 1'b0; mode = ~m; input_bit = ~ib; cond_mask = ~mk; cond_value = ~cv;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; mode = 2'b01;
        input_bit = '0; cond_mask = '0; cond_value = '0; arr_if = IfSegs; arr_else = ElseSegs;
        step(); step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", m_valid); end
        checks++; if (m_seg !== 32'h0) begin errors++; $display("FAIL rst_seg got %0h want 0", m_seg); end
        checks++; if (m_chan !== 2'd0) begin errors++; $display("FAIL rst_chan got %0h want 0", m_chan); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0h want 0", m_last); end
        checks++; if (m_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0h want 0", m_cnt); end
        reset = 1'b1; in_valid = 1'b0;
        step();
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h want 1", m_in_ready); end
        step(); step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_ignored_valid got %0h want 0", m_valid); end
    endtask

    task automatic test_match();
        start_txn(2'b00, 32'h0000_00A5, 32'hFF, 32'hA5);
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL eval_in_ready got %0h want 0", m_in_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL eval_valid got %0h want 0", m_valid); end
        step();
        exp_cnt = 1;
        checks++; if (m_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL match_cnt got %0d want %0d", m_cnt, exp_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL match_valid%0d got %0h want 1", k, m_valid); end
            checks++; if (m_seg !== 32'(k + 1)) begin errors++; $display("FAIL match_seg%0d got %0h want %0h", k, m_seg, k + 1); end
            checks++; if (m_chan !== 2'(k)) begin errors++; $display("FAIL match_chan%0d got %0h want %0h", k, m_chan, k); end
            checks++; if (m_last !== (k == 3)) begin errors++; $display("FAIL match_last%0d got %0h want %0h", k, m_last, k == 3); end
            checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL stream_in_ready%0d got %0h want 0", k, m_in_ready); end
            step();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL match_end_valid got %0h want 0", m_valid); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL match_end_ready got %0h want 1", m_in_ready); end
        checks++; if (m_seg !== 32'h0) begin errors++; $display("FAIL match_end_seg got %0h want 0", m_seg); end
    endtask

    logic [1:0]  t_mode [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [31:0] t_bit  [6] = '{32'hA5, 32'hA5, 32'h1234_5678, 32'hA5, 32'hDEAD_BEEF, 32'h1A5};
    logic [31:0] t_mask [6] = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'h0, 32'h0F};
    logic [31:0] t_val  [6] = '{32'hA4, 32'hA4, 32'h0, 32'hA5, 32'h1234, 32'h5};
    logic        t_if   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic test_modes();
        for (int t = 0; t < 6; t++) begin
            start_txn(t_mode[t], t_bit[t], t_mask[t], t_val[t]);
            step();
            if (t_if[t]) exp_cnt++;
            checks++; if (m_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL modes%0d_cnt got %0d want %0d", t, m_cnt, exp_cnt); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (m_seg !== (t_if[t] ? 32'(k + 1) : 32'd9) || m_chan !== 2'(k) || m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL modes%0d_beat%0d got seg %0h chan %0h want seg %0h chan %0h",
                             t, k, m_seg, m_chan, t_if[t] ? k + 1 : 9, k);
                end
                step();
            end
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL modes%0d_end got %0h want 0", t, m_valid); end
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int k;
        int c;
        pat = 4'b1001;
        start_txn(2'b01, 32'h0, 32'h0, 32'h0);
        step();
        exp_cnt++;
        k = 0;
        c = 0;
        while (k < 4 && c < 24) begin
            checks++;
            if (m_valid !== 1'b1 || m_seg !== 32'(k + 1) || m_chan !== 2'(k) || m_last !== (k == 3)) begin
                errors++;
                $display("FAIL stall_c%0d got v%0h seg %0h chan %0h last %0h want v1 seg %0h chan %0h last %0h",
                         c, m_valid, m_seg, m_chan, m_last, k + 1, k, k == 3);
            end
            out_ready = pat[c % 4];
            arr_if = ~arr_if;
            arr_else = ~arr_else;
            step();
            if (out_ready) k++;
            c++;
        end
        checks++; if (k != 4) begin errors++; $display("FAIL stall_timeout got %0d beats want 4", k); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_end got %0h want 0", m_valid); end
        checks++; if (m_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", m_cnt, exp_cnt); end
        out_ready = 1'b1; arr_if = IfSegs; arr_else = ElseSegs;
    endtask

    task automatic test_reset_abort();
        start_txn(2'b01, 32'h0, 32'h0, 32'h0);
        step();
        step();
        checks++; if (m_chan !== 2'd1) begin errors++; $display("FAIL abort_pre_chan got %0h want 1", m_chan); end
        reset = 1'b0;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0h want 0", m_valid); end
        checks++; if (m_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", m_cnt); end
        checks++; if (s_cnt !== 2'd0) begin errors++; $display("FAIL abort_sat_cnt got %0d want 0", s_cnt); end
        reset = 1'b1;
        exp_cnt = 0;
        step();
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %0h want 1", m_in_ready); end
        start_txn(2'b10, 32'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 2'd0 || m_seg !== 32'd9) begin
            errors++;
            $display("FAIL abort_restart got v%0h chan %0h seg %0h want v1 chan 0 seg 9", m_valid, m_chan, m_seg);
        end
        repeat (4) step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_restart_end got %0h want 0", m_valid); end
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got %0h want 1", i, m_in_ready); end
            start_txn(2'b01, 32'h0, 32'h0, 32'h0);
            step();
            exp_cnt++;
            checks++; if (s_cnt !== 2'(sat_exp[i])) begin errors++; $display("FAIL sat%0d got %0d want %0d", i, s_cnt, sat_exp[i]); end
            repeat (4) step();
        end
        checks++; if (m_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", m_cnt, exp_cnt); end
    endtask

    task automatic test_single_channel();
        for (int i = 0; i < 2; i++) begin
            start_txn(i == 0 ? 2'b01 : 2'b10, 32'h0, 32'h0, 32'h0);
            step();
            checks++;
            if (o_valid !== 1'b1 || o_last !== 1'b1 || o_chan !== 1'b0 || o_seg !== (i == 0 ? 32'd1 : 32'd9)) begin
                errors++;
                $display("FAIL one%0d got v%0h last %0h chan %0h seg %0h want v1 last 1 chan 0 seg %0h",
                         i, o_valid, o_last, o_chan, o_seg, i == 0 ? 1 : 9);
            end
            step();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL one%0d_end got %0h want 0", i, o_valid); end
            checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL one%0d_ready got %0h want 1", i, o_in_ready); end
            repeat (3) step();
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_modes();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        test_single_channel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
